dct_mac_acc: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for the `fdct_zigzag` DCT datapath, generalising the fixed-width `macu` result register. It accepts a stream of signed sample/coefficient pairs and sums each group of `TERMS` products. It scales each completed sum to `OUT_W` bits and presents it on a valid/ready output with full backpressure. One instance serves one DCT output coefficient lane; `dct_block_*` instantiates several in parallel.

---
 rtl/dct_mac_acc.sv | 146 ++++++++++++++
 tb/tb_dct_mac_acc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_acc.sv
// dct_mac_acc - pipelined signed multiply-accumulate for one DCT coefficient lane.
//
// Sums every group of TERMS din*coef products, scales the sum by FRAC bits to
// OUT_W bits and holds it in a valid/ready output register with full
// backpressure. Consecutive blocks stream with no bubble.
//
// Optional feature: define DCT_MAC_ROUND_EN to round half-up and saturate the
// scaled result. Without it the result is truncated (toward -inf) and wraps.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake for one din/coef pair
//   din, coef           signed sample and coefficient
//   out_valid/out_ready output handshake for one scaled sum
//   result              signed scaled sum (held while out_valid && !out_ready)
//   busy                registered: partial block counted or product stage occupied
module dct_mac_acc #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int TERMS  = 8,
    parameter int ACC_W  = 24,
    parameter int FRAC   = 8,
    parameter int OUT_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] din,
    input  logic signed [COEF_W-1:0] coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  result,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TERMS);

    logic [CNT_W-1:0]        tcnt_q, tcnt_d;
    logic                    p_valid_q, p_valid_d;
    logic                    p_first_q, p_first_d;
    logic                    p_last_q, p_last_d;
    logic signed [ACC_W-1:0] p_q, p_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] result_q, result_d;
    logic                    busy_q, busy_d;

    logic                    en, accept, load;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] scaled;

`ifdef DCT_MAC_ROUND_EN
    // One extra bit so adding the half-LSB cannot overflow before the shift.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] rsh;

    always_comb begin
        rnd = {sum[ACC_W-1], sum} + HALF;
        rsh = rnd >>> FRAC;
        if (rsh > SAT_MAX) begin
            scaled = SAT_MAX[OUT_W-1:0];
        end else if (rsh < SAT_MIN) begin
            scaled = SAT_MIN[OUT_W-1:0];
        end else begin
            scaled = OUT_W'(rsh);
        end
    end
`else
    always_comb begin
        scaled = OUT_W'(sum >>> FRAC);
    end
`endif

    always_comb begin
        en     = !out_valid_q || out_ready;
        accept = in_valid && en;
        prod   = din * coef;

        // Stage 0/1: count accepted pairs and register the product with its tags.
        tcnt_d    = tcnt_q;
        p_valid_d = p_valid_q;
        p_first_d = p_first_q;
        p_last_d  = p_last_q;
        p_d       = p_q;
        if (en) begin
            p_valid_d = accept;
            p_first_d = (tcnt_q == '0);
            p_last_d  = (tcnt_q == CNT_W'(TERMS - 1));
            p_d       = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            if (accept) begin
                tcnt_d = (tcnt_q == CNT_W'(TERMS - 1)) ? '0 : tcnt_q + CNT_W'(1);
            end
        end

        // Stage 2: a first term restarts the sum, so the running total and the
        // completed block sum are the same expression.
        sum  = p_first_q ? p_q : acc_q + p_q;
        load = en && p_valid_q && p_last_q;

        acc_d = acc_q;
        if (en && p_valid_q) begin
            acc_d = sum;
        end

        result_d    = load ? scaled : result_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        busy_d      = (tcnt_d != '0) || p_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q      <= '0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            tcnt_q      <= tcnt_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dct_mac_acc.sv
// Directed bench for dct_mac_acc with default parameters.
// Expected values follow DCT_MAC_ROUND_EN when the bench is built with it.
module tb_dct_mac_acc;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  din;
    logic signed [11:0] coef;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] result;
    logic               busy;

    int n_chk;
    int n_fail;

    dct_mac_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .coef      (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full block: first pair (d0,c0), then TERMS-1 pairs (dr,cr), out_ready=1.
    task automatic blk(input logic signed [7:0] d0, input logic signed [11:0] c0,
                       input logic signed [7:0] dr, input logic signed [11:0] cr,
                       input string tag, input logic signed [31:0] exp);
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = (i == 0) ? d0 : dr;
            coef     = (i == 0) ? c0 : cr;
            @(negedge clk);
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, result, exp);
        @(negedge clk);
        check({tag, "_single"}, out_valid, 0);
    endtask

    int idx, nres, npulse, first_c, last_c, drops;
    logic signed [11:0] res [0:3];
    logic signed [11:0] r0, r1;

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; din = '0; coef = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Basic: 1..8 * 256 >> 8 = 36
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = 8'(i + 1);
            coef     = 12'sd256;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("basic_not_yet", out_valid, 0);
        check("basic_busy_mid", busy, 1);
        @(negedge clk);
        check("basic_valid", out_valid, 1);
        check("basic_result", result, 36);
        check("basic_busy_idle", busy, 0);
        @(negedge clk);
        check("basic_pulse", out_valid, 0);

        // Backpressure: block1 = 36, block2 = 8*2*256>>8 = 16; stall for 5 cycles.
        idx = 0; nres = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 14) out_ready = 1'b1;
            in_valid = (idx < 16);
            din      = (idx < 8) ? 8'(idx + 1) : 8'sd2;
            coef     = 12'sd256;
            #1;
            if (c >= 9 && c < 14) begin
                check("bp_stall_in_ready", in_ready, 0);
                check("bp_stall_result", result, 36);
            end
            if (out_valid && out_ready) begin
                if (nres < 4) res[nres] = result;
                nres++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_accepted", idx, 16);
        check("bp_count", nres, 2);
        check("bp_res0", res[0], 36);
        check("bp_res1", res[1], 16);

        // Throughput: 16 pairs, two pulses 8 cycles apart, in_ready stays high.
        npulse = 0; first_c = -1; last_c = -1; drops = 0; r0 = '0; r1 = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16);
            din      = (c < 8) ? 8'sd1 : 8'sd2;
            coef     = 12'sd256;
            #1;
            if (!in_ready) drops++;
            if (out_valid) begin
                npulse++;
                if (npulse == 1) begin first_c = c; r0 = result; end
                else begin last_c = c; r1 = result; end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("tp_pulses", npulse, 2);
        check("tp_latency", first_c, 9);
        check("tp_spacing", last_c - first_c, 8);
        check("tp_res0", r0, 8);
        check("tp_res1", r1, 16);
        check("tp_in_ready_drops", drops, 0);

        // Rounding and saturation corners.
`ifdef DCT_MAC_ROUND_EN
        blk(8'sd1, 12'sd128, 8'sd0, 12'sd0, "rnd_pos", 1);
        blk(-8'sd1, 12'sd128, 8'sd0, 12'sd0, "rnd_neg", 0);
        blk(8'sd127, 12'sd2047, 8'sd127, 12'sd2047, "sat", 2047);
`else
        blk(8'sd1, 12'sd128, 8'sd0, 12'sd0, "rnd_pos", 0);
        blk(-8'sd1, 12'sd128, 8'sd0, 12'sd0, "rnd_neg", -1);
        blk(8'sd127, 12'sd2047, 8'sd127, 12'sd2047, "sat", -68);
`endif

        // Reset mid-block: partial block discarded, rst beats in_valid.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            din      = 8'sd5;
            coef     = 12'sd256;
            @(negedge clk);
        end
        check("mid_busy", busy, 1);
        rst = 1'b1; in_valid = 1'b1; din = 8'sd100; coef = 12'sd100;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        blk(8'sd1, 12'sd256, 8'sd1, 12'sd256, "mid_blk", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
